mem_rmw_ctrl: RTL and testbench
===============================

Name: mem_rmw_ctrl

Overview:
- Data-memory access controller in the MEM stage. It drives a synchronous, word-only, single-port data RAM.
- Word stores are single-cycle writes.
- Byte and halfword stores (sb/sh) run as a two-cycle read-modify-write. The controller raises need_stall, which the hazard logic uses to stall the next memory instruction and bubble EX/MEM.
- Loads are issued to the RAM, and the returned word is extracted and extended one cycle later for WB.

Parameters:
- ADDR_W, 32, byte-address width from the EX/MEM register.
- RAM_AW, 12, RAM word-address width; ram_addr = addr[RAM_AW+1:2].

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- mem_ren  in  1  EX/MEM load valid
- mem_wen  in  1  EX/MEM store valid
- mask_mode  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- load_sext  in  1  1 = sign-extend sub-word load
- addr  in  ADDR_W  byte address
- wdata  in  32  store data; value in low bits
- need_stall  out  1  sub-word store in MEM this cycle; to hazard unit
- busy  out  1  RMW write phase in progress
- ram_addr  out  RAM_AW  RAM word address
- ram_we  out  1  RAM write enable (whole word)
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after the address
- load_data  out  32  aligned/extended load result, valid the cycle after mem_ren

Behaviour:
- Reset: state=IDLE. ram_we=0, need_stall=0, busy=0, load_data=0, all latched fields=0.
- Reset mid-RMW: the pending write is abandoned and no write is issued.
- States: IDLE, RMW_WR.
- IDLE, decoded combinationally:
  - Word store (mem_wen, mask 10/11): ram_addr from addr, ram_wdata=wdata, ram_we=1. Stay IDLE.
  - Load (mem_ren): ram_addr from addr, ram_we=0. Register addr[1:0], mask_mode and load_sext into ld_* for the next cycle.
  - Sub-word store (mem_wen, mask 00/01): ram_addr from addr, ram_we=0 (read), need_stall=1. Latch word address, addr[1:0], mask and wdata. Go to RMW_WR.
  - mem_ren and mem_wen both high: the store wins and the load is ignored.
- RMW_WR:
  - busy=1, ram_we=1, ram_addr = latched word address.
  - ram_wdata = ram_rdata with the selected lane replaced:
    - byte: lane addr[1:0] gets wdata[7:0];
    - half: lane addr[1] (bits 15:0 or 31:16) gets wdata[15:0].
  - Always return to IDLE next cycle.
  - need_stall=0. Request inputs are ignored; the hazard unit guarantees a bubble here.
- Load extraction, the cycle after a load:
  - byte: ram_rdata[8*ld_off+:8]
  - half: ram_rdata[16*ld_off[1]+:16]
  - word: as is
  - Sign- or zero-extend per ld_sext.
  - load_data is combinational from ram_rdata and the ld_* registers. It holds its last value when the previous cycle was not a load.
- Halfword with addr[0]=1: addr[0] is ignored (treated as aligned) unless the optional feature is enabled.
- Consecutive word stores or loads: one per cycle, no stall.
- Sub-word store immediately after a load: allowed. The load result is extracted in the same cycle the RMW read is issued.

Optional Feature:
- MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_err (1 bit, registered, reset 0).
  - It is set for one cycle after a half access with addr[0]=1 or a word access with addr[1:0]!=0.
  - A misaligned store issues no write and does not assert need_stall.
  - A misaligned load returns load_data=0.
- Undefined: the port is absent and low address bits are ignored as above.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> ram_we=1 for 1 cycle, need_stall never set. Next cycle load_data=0xDEADBEEF.
- Word 0x11223344 @0x20; sb wdata=0xAA @0x21 -> need_stall=1 in cycle 0, ram_we=0. Cycle 1: busy=1, ram_we=1, ram_wdata=0x1122AA44.
- Word 0x11223344 @0x20; sh 0xBEEF @0x22 -> ram_wdata=0xBEEF3344. Then lh @0x22 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
- lb @0x23 on 0x80FF0000 -> 0xFFFFFF80; lbu -> 0x00000080.
- rst_n low during RMW_WR -> ram_we=0 immediately, state IDLE, RAM word unchanged.
- With MEM_MISALIGN_TRAP_EN, sh @0x21 -> no ram_we, need_stall=0, misalign_err=1 for one cycle.

Source files
------------

// File: rtl/mem_rmw_ctrl.sv
// MEM-stage data RAM controller: single-cycle word stores, two-cycle read-modify-write
// for sb/sh, and next-cycle load extraction. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mem_rmw_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [1:0]        mask_mode,
  input  logic              load_sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              need_stall,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       load_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state, state_next;
  logic [RAM_AW-1:0] rmw_addr;
  logic [1:0]        rmw_off;
  logic              rmw_half;
  logic [15:0]       rmw_wdata;
  logic              ld_valid;
  logic [1:0]        ld_off;
  logic [1:0]        ld_mask;
  logic              ld_sext;
  logic [31:0]       load_q;
  logic [31:0]       merged;
  logic              st_sub;
  logic              ld_go;
  logic              mis;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[ADDR_W-1:RAM_AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
  logic ld_mis;
  assign mis = ((mask_mode == 2'b01) && addr[0]) || (mask_mode[1] && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_next = state;
    need_stall = 1'b0;
    busy       = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr[RAM_AW+1:2];
    ram_wdata  = wdata;
    st_sub     = 1'b0;
    ld_go      = 1'b0;
    case (state)
      IDLE: begin
        // A store takes priority over a simultaneous load.
        if (mem_wen) begin
          if (!mis) begin
            if (mask_mode[1]) begin
              ram_we = 1'b1;
            end else begin
              need_stall = 1'b1;
              st_sub     = 1'b1;
              state_next = RMW_WR;
            end
          end
        end else if (mem_ren) begin
          ld_go = 1'b1;
        end
      end
      RMW_WR: begin
        busy       = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = rmw_addr;
        ram_wdata  = merged;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    merged = ram_rdata;
    if (!rmw_half) begin
      merged[{rmw_off, 3'b000} +: 8] = rmw_wdata[7:0];
    end else if (rmw_off[1]) begin
      merged[31:16] = rmw_wdata;
    end else begin
      merged[15:0] = rmw_wdata;
    end
  end

  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb        = ram_rdata[{ld_off, 3'b000} +: 8];
    lh        = ram_rdata[{ld_off[1], 4'b0000} +: 16];
    load_data = load_q;
    if (ld_valid) begin
      case (ld_mask)
        2'b00:   load_data = {{24{ld_sext & lb[7]}}, lb};
        2'b01:   load_data = {{16{ld_sext & lh[15]}}, lh};
        default: load_data = ram_rdata;
      endcase
`ifdef MEM_MISALIGN_TRAP_EN
      if (ld_mis) load_data = 32'h0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rmw_addr  <= '0;
      rmw_off   <= 2'b00;
      rmw_half  <= 1'b0;
      rmw_wdata <= 16'h0;
      ld_valid  <= 1'b0;
      ld_off    <= 2'b00;
      ld_mask   <= 2'b00;
      ld_sext   <= 1'b0;
      load_q    <= 32'h0;
    end else begin
      state    <= state_next;
      ld_valid <= ld_go;
      load_q   <= load_data;
      if (st_sub) begin
        rmw_addr  <= addr[RAM_AW+1:2];
        rmw_off   <= addr[1:0];
        rmw_half  <= mask_mode[0];
        rmw_wdata <= wdata[15:0];
      end
      if (ld_go) begin
        ld_off  <= addr[1:0];
        ld_mask <= mask_mode;
        ld_sext <= load_sext;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_mis       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= (state == IDLE) && (mem_ren || mem_wen) && mis;
      if (ld_go) ld_mis <= mis;
    end
  end
`endif

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: vector table with a load-result scoreboard, behavioural sync RAM,
// plus hand sequences for reset mid-RMW, load hold and (if enabled) the misalignment trap.
module tb_mem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ren, mem_wen, load_sext;
  logic [1:0]  mask_mode;
  logic [31:0] addr, wdata;
  logic        need_stall, busy, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata, load_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  mem_rmw_ctrl #(.ADDR_W(32), .RAM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mask_mode(mask_mode), .load_sext(load_sext), .addr(addr), .wdata(wdata),
    .need_stall(need_stall), .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .load_data(load_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        ren;
    logic        wen;
    logic [1:0]  mask;
    logic        sext;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_q[$];
  bit          pend;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic vec_t mk(logic r, logic w, logic [1:0] m, logic s,
                              logic [31:0] a, logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.ren = r; v.wen = w; v.mask = m; v.sext = s; v.a = a; v.d = d; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_check();
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL scoreboard: load result due but queue empty");
      end else begin
        chk("load_data", load_data, exp_q.pop_front());
      end
    end
    pend = 0;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] m, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mem_ren = r; mem_wen = w; mask_mode = m; load_sext = s; addr = a; wdata = d;
  endtask

  task automatic apply(input vec_t v);
    drive(v.ren, v.wen, v.mask, v.sext, v.a, v.d);
    @(negedge clk);
    sb_check();
    if (v.wen) begin
      chk("store ram_addr", ram_addr, v.a[13:2]);
      if (v.mask[1]) begin
        chk("sw ram_we", ram_we, 1);
        chk("sw need_stall", need_stall, 0);
        chk("sw ram_wdata", ram_wdata, v.exp);
      end else begin
        chk("sub need_stall", need_stall, 1);
        chk("sub read ram_we", ram_we, 0);
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rmw busy", busy, 1);
        chk("rmw ram_we", ram_we, 1);
        chk("rmw need_stall", need_stall, 0);
        chk("rmw ram_addr", ram_addr, v.a[13:2]);
        chk("rmw ram_wdata", ram_wdata, v.exp);
      end
    end else if (v.ren) begin
      chk("load ram_we", ram_we, 0);
      chk("load need_stall", need_stall, 0);
      exp_q.push_back(v.exp);
      pend = 1;
    end
  endtask

  initial begin
    // ren wen mask sext addr wdata expected(ram_wdata for stores, load_data for loads)
    vq.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF));
    vq.push_back(mk(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h11223344));
    vq.push_back(mk(0, 1, 2'b00, 0, 32'h21, 32'h000000AA, 32'h1122AA44));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h1122AA44));
    vq.push_back(mk(0, 1, 2'b11, 0, 32'h20, 32'h11223344, 32'h11223344));
    vq.push_back(mk(0, 1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'hBEEF3344));
    vq.push_back(mk(1, 0, 2'b01, 1, 32'h22, 32'h0,        32'hFFFFBEEF));
    vq.push_back(mk(1, 0, 2'b01, 0, 32'h22, 32'h0,        32'h0000BEEF));
    vq.push_back(mk(0, 1, 2'b10, 0, 32'h20, 32'h80FF0000, 32'h80FF0000));
    vq.push_back(mk(1, 0, 2'b00, 1, 32'h23, 32'h0,        32'hFFFFFF80));
    vq.push_back(mk(1, 0, 2'b00, 0, 32'h23, 32'h0,        32'h00000080));
    vq.push_back(mk(1, 0, 2'b00, 1, 32'h22, 32'h0,        32'hFFFFFFFF));
    vq.push_back(mk(1, 0, 2'b00, 0, 32'h21, 32'h0,        32'h00000000));
    vq.push_back(mk(1, 0, 2'b01, 1, 32'h22, 32'h0,        32'hFFFF80FF));
    vq.push_back(mk(1, 0, 2'b01, 1, 32'h20, 32'h0,        32'h00000000));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h80FF0000));
    vq.push_back(mk(0, 1, 2'b01, 0, 32'h20, 32'h00001234, 32'h80FF1234));
    vq.push_back(mk(0, 1, 2'b00, 0, 32'h23, 32'h0000005A, 32'h5AFF1234));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h5AFF1234));
`ifndef MEM_MISALIGN_TRAP_EN
    vq.push_back(mk(0, 1, 2'b01, 0, 32'h21, 32'h0000CAFE, 32'h5AFFCAFE));
    vq.push_back(mk(1, 0, 2'b01, 0, 32'h23, 32'h0,        32'h00005AFF));
`endif
    vq.push_back(mk(1, 1, 2'b10, 0, 32'h40, 32'h01020304, 32'h01020304));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h40, 32'h0,        32'h01020304));
    vq.push_back(mk(1, 0, 2'b00, 1, 32'h40, 32'h0,        32'h00000004));

    rst_n = 1'b0; pend = 0;
    mem_ren = 0; mem_wen = 0; mask_mode = 2'b00; load_sext = 0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ram_we", ram_we, 0);
    chk("reset need_stall", need_stall, 0);
    chk("reset busy", busy, 0);
    chk("reset load_data", load_data, 0);
    rst_n = 1'b1;

    foreach (vq[i]) apply(vq[i]);

    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    sb_check();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("load_data hold idle", load_data, 32'h4);
    apply(mk(0, 1, 2'b10, 0, 32'h60, 32'h55AA55AA, 32'h55AA55AA));
    chk("load_data hold store", load_data, 32'h4);

    // Reset arriving during the RMW write phase must drop the write.
    apply(mk(0, 1, 2'b10, 0, 32'h50, 32'h11111111, 32'h11111111));
    drive(0, 1, 2'b00, 0, 32'h50, 32'h000000FF);
    @(negedge clk);
    chk("pre-reset need_stall", need_stall, 1);
    @(posedge clk); #1;
    mem_wen = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid-rmw reset ram_we", ram_we, 0);
    chk("mid-rmw reset busy", busy, 0);
    chk("mid-rmw reset load_data", load_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pend = 0; exp_q.delete();
    apply(mk(1, 0, 2'b10, 0, 32'h50, 32'h0, 32'h11111111));
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    sb_check();

`ifdef MEM_MISALIGN_TRAP_EN
    drive(0, 1, 2'b01, 0, 32'h21, 32'h0000CAFE);
    @(negedge clk);
    chk("mis store ram_we", ram_we, 0);
    chk("mis store need_stall", need_stall, 0);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mis store err", misalign_err, 1);
    chk("mis store no rmw", busy, 0);
    drive(1, 0, 2'b10, 0, 32'h22, 32'h0);
    exp_q.push_back(32'h0); pend = 1;
    @(negedge clk);
    chk("mis err one cycle", misalign_err, 0);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    sb_check();
    chk("mis load err", misalign_err, 1);
    apply(mk(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h5AFF1234));
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    sb_check();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
